nic_pwr_seq: RTL

NIC_PWR_SEQ -- requirements
Module: nic_pwr_seq

---
 rtl/nic_seq_pkg.sv | 35 +++
 rtl/nic_seq_timer.sv | 36 +++
 rtl/nic_pwr_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/nic_seq_pkg.sv
// ============================================================================
// Module   : nic_seq_pkg
// Brief    : State encodings, default delays and helpers for the NIC power
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nic_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE          = 4'd0,
        ST_AUX_ON        = 4'd1,
        ST_AUX_MAIN_WAIT = 4'd2,
        ST_MAIN_ON       = 4'd3,
        ST_PERST_WAIT    = 4'd4,
        ST_RUN           = 4'd5,
        ST_DN_MAIN       = 4'd6,
        ST_DN_AUX        = 4'd7,
        ST_FAULT         = 4'd8
    } state_t;

    localparam logic [15:0] c_DEF_AUX_MAIN_DLY = 16'd100;
    localparam logic [15:0] c_DEF_PERST_DLY    = 16'd1000;
    localparam logic [15:0] c_DEF_PG_TIMEOUT   = 16'd5000;
    localparam logic [15:0] c_DEF_OFF_DLY      = 16'd100;

    // A zero-length wait would never produce an expire pulse, so clamp to 1.
    function automatic logic [15:0] f_dur(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nic_seq_timer.sv
// ============================================================================
// Module   : nic_seq_timer
// Brief    : 16-bit saturating down-counter with load, enable and expire.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nic_seq_timer
    import nic_seq_pkg::*;
(
    input  logic        clk_in,
    input  logic        iRst_n,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    input  logic        i_en,
    output logic        o_expire
);

    logic [15:0] r_count;

    always_ff @(posedge clk_in or negedge iRst_n) begin
        if (!iRst_n) begin
            r_count <= 16'd0;
        end else if (i_load) begin
            r_count <= f_dur(i_load_val);
        end else if (i_en && (r_count != 16'd0)) begin
            r_count <= r_count - 16'd1;
        end
    end

    // Fires during the last cycle of the wait, so a wait of N spans N cycles.
    assign o_expire = i_en && (r_count == 16'd1);

endmodule

`default_nettype wire

// File: rtl/nic_pwr_seq.sv
// ============================================================================
// Module   : nic_pwr_seq
// Brief    : NIC aux/main rail power sequencer with PERST# control and fault.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nic_pwr_seq
    import nic_seq_pkg::*;
#(
    parameter logic [15:0] AUX_MAIN_DLY = c_DEF_AUX_MAIN_DLY,
    parameter logic [15:0] PERST_DLY    = c_DEF_PERST_DLY,
    parameter logic [15:0] PG_TIMEOUT   = c_DEF_PG_TIMEOUT,
    parameter logic [15:0] OFF_DLY      = c_DEF_OFF_DLY
) (
    input  logic       clk_in,
    input  logic       iRst_n,
    input  logic       iPwrEn,
    input  logic       iPresent_n,
    input  logic       iAuxPg,
    input  logic       iMainPg,
    output logic       oAuxEn,
    output logic       oMainEn,
    output logic       oPerst_n,
    output logic       oPwrGood,
    output logic       oFault,
    output logic [3:0] oState
);

    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    state_t      r_state;
    state_t      w_next;
    logic        r_aux_en;
    logic        r_main_en;
    logic        r_perst_n;
    logic        r_pwr_good;
    logic        r_fault;
    logic        w_aux_en_nxt;
    logic        w_main_en_nxt;
    logic        w_abort;
    logic        w_tmr_en;
    logic        w_tmr_load;
    logic [15:0] w_load_val;
    logic        w_expire;
    logic        w_pwr_en;
    logic        w_present_n;
    logic        w_aux_pg;
    logic        w_main_pg;

    always_ff @(posedge clk_in or negedge iRst_n) begin
        if (!iRst_n) begin
            r_sync1 <= 4'd0;
            r_sync2 <= 4'd0;
        end else begin
            r_sync1 <= {iPwrEn, iPresent_n, iAuxPg, iMainPg};
            r_sync2 <= r_sync1;
        end
    end

    assign w_pwr_en    = r_sync2[3];
    assign w_present_n = r_sync2[2];
    assign w_aux_pg    = r_sync2[1];
    assign w_main_pg   = r_sync2[0];
    assign w_abort     = !w_pwr_en || w_present_n;

    assign w_tmr_en = (r_state == ST_AUX_ON)     || (r_state == ST_AUX_MAIN_WAIT) ||
                      (r_state == ST_MAIN_ON)    || (r_state == ST_PERST_WAIT)    ||
                      (r_state == ST_DN_MAIN)    || (r_state == ST_DN_AUX);
    assign w_tmr_load = (w_next != r_state);

    nic_seq_timer u_timer (
        .clk_in     (clk_in),
        .iRst_n     (iRst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_load_val),
        .i_en       (w_tmr_en),
        .o_expire   (w_expire)
    );

    // PG beats timeout in the ramp states; PG loss beats an off request in RUN.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:          if (w_pwr_en && !w_present_n) w_next = ST_AUX_ON;
            ST_AUX_ON:        if (w_abort)        w_next = ST_DN_MAIN;
                              else if (w_aux_pg)  w_next = ST_AUX_MAIN_WAIT;
                              else if (w_expire)  w_next = ST_FAULT;
            ST_AUX_MAIN_WAIT: if (w_abort)        w_next = ST_DN_MAIN;
                              else if (w_expire)  w_next = ST_MAIN_ON;
            ST_MAIN_ON:       if (w_abort)        w_next = ST_DN_MAIN;
                              else if (w_main_pg) w_next = ST_PERST_WAIT;
                              else if (w_expire)  w_next = ST_FAULT;
            ST_PERST_WAIT:    if (w_abort)        w_next = ST_DN_MAIN;
                              else if (w_expire)  w_next = ST_RUN;
            ST_RUN:           if (!w_aux_pg || !w_main_pg) w_next = ST_FAULT;
                              else if (w_abort)            w_next = ST_DN_MAIN;
            ST_DN_MAIN:       if (w_expire)       w_next = ST_DN_AUX;
            ST_DN_AUX:        if (w_expire)       w_next = ST_IDLE;
            ST_FAULT:         if (!w_pwr_en)      w_next = ST_IDLE;
            default:          w_next = ST_IDLE;
        endcase

        w_load_val = 16'd0;
        case (w_next)
            ST_AUX_ON, ST_MAIN_ON:  w_load_val = PG_TIMEOUT;
            ST_AUX_MAIN_WAIT:       w_load_val = AUX_MAIN_DLY;
            ST_PERST_WAIT:          w_load_val = PERST_DLY;
            ST_DN_MAIN, ST_DN_AUX:  w_load_val = OFF_DLY;
            default:                w_load_val = 16'd0;
        endcase

        // Power-down states hold whatever rails were actually on.
        w_aux_en_nxt  = 1'b0;
        w_main_en_nxt = 1'b0;
        case (w_next)
            ST_AUX_ON, ST_AUX_MAIN_WAIT: w_aux_en_nxt = 1'b1;
            ST_MAIN_ON, ST_PERST_WAIT, ST_RUN: begin
                w_aux_en_nxt  = 1'b1;
                w_main_en_nxt = 1'b1;
            end
            ST_DN_MAIN: begin
                w_aux_en_nxt  = r_aux_en;
                w_main_en_nxt = r_main_en;
            end
            ST_DN_AUX:  w_aux_en_nxt = r_aux_en;
            default: begin
                w_aux_en_nxt  = 1'b0;
                w_main_en_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state    <= ST_IDLE;
            r_aux_en   <= 1'b0;
            r_main_en  <= 1'b0;
            r_perst_n  <= 1'b0;
            r_pwr_good <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_aux_en   <= w_aux_en_nxt;
            r_main_en  <= w_main_en_nxt;
            r_perst_n  <= (w_next == ST_RUN);
            r_pwr_good <= (w_next == ST_RUN);
            r_fault    <= (w_next == ST_FAULT);
        end
    end

    assign oAuxEn   = r_aux_en;
    assign oMainEn  = r_main_en;
    assign oPerst_n = r_perst_n;
    assign oPwrGood = r_pwr_good;
    assign oFault   = r_fault;
    assign oState   = r_state;

endmodule

`default_nettype wire
